button_encoder: RTL and testbench
=================================

// Module: button_encoder
// PURPOSE
//  Producer side of the game controller's IN/IN_VALID interface. Takes the four raw
//  asynchronous colour buttons, synchronises and debounces them, and encodes a clean
//  single-button press into a 2-bit colour code with a one-cycle IN_VALID strobe.
//  Sits between the board pins and the controller. Emits one strobe per physical press.
// PARAMETERS
//  SYNC_STAGES      2   flops in the input synchroniser, per button (>=2)
//  DEBOUNCE_CYCLES  16  consecutive identical samples needed to accept a press or a release (>=2)
// PORTS
//  CLK       in   1  system clock
//  RST       in   1  synchronous, active-high reset
//  BTN       in   4  raw buttons, active-high, asynchronous; BTN[k] = colour k
//  ENABLE    in   1  1 = accepted presses are reported; 0 = presses are debounced, then discarded
//  IN        out  2  encoded colour of the last reported press
//  IN_VALID  out  1  one-cycle strobe; IN is valid while it is high
//  MULTI     out  1  one-cycle strobe: a debounced press had more than one button down
//  KEY_DOWN  out  1  level: OR of the synchronised buttons
// BEHAVIOUR
//  Reset (RST high at a CLK edge): all synchroniser flops 0, state RELEASE_S, count 0,
//   latched pattern 0, IN=0, IN_VALID=0, MULTI=0. KEY_DOWN follows the cleared synchroniser (0).
//   Reset works identically mid-debounce; no strobe from a press interrupted by reset.
//  sync[3:0] = synchroniser output. KEY_DOWN = |sync (combinational from sync).
//  Count width is clog2(DEBOUNCE_CYCLES)+1. The count saturates and never wraps.
//  IN_VALID and MULTI default to 0 every cycle; they are registered pulses.
//  FSM:
//   RELEASE_S: if sync!=0, count=0.
//    Else if count==DEBOUNCE_CYCLES-1, go to ARMED_S and clear count.
//    Else count++.
//   ARMED_S: if sync!=0, latch pat=sync, count=0, go to PRESS_S.
//   PRESS_S:
//    if sync!=pat (release, bounce or pattern change), go to ARMED_S with no strobe.
//    else if count==DEBOUNCE_CYCLES-1, accept the press and go to RELEASE_S with count=0:
//     pat one-hot and ENABLE=1: IN<=index of the set bit, IN_VALID<=1.
//     pat one-hot and ENABLE=0: no strobe; IN holds.
//     pat multi-hot: MULTI<=1 whatever ENABLE is; IN holds.
//    else count++.
//  ENABLE is sampled only on the accepting edge.
//  Latency: the first CLK edge that samples BTN high is e0. The button is stable, the block
//   is in ARMED_S, and no other buttons change. Then IN_VALID is high in the cycle after
//   edge e0+SYNC_STAGES+DEBOUNCE_CYCLES (defaults: 18 edges).
//  A held button gives exactly one strobe. Re-arming needs all buttons released for
//   DEBOUNCE_CYCLES consecutive samples.
//  Encoding: BTN[0]->0, BTN[1]->1, BTN[2]->2, BTN[3]->3, the same code space as the controller's OUT.
//  After reset, any buttons held are ignored until a full debounced release.
//  IN_VALID and MULTI are never high in the same cycle.
// TESTING
//  1 Reset, no buttons for 16+ cycles, then BTN=4'b0100 held 30 cycles
//    -> exactly one IN_VALID pulse, IN=2, at edge e0+18. MULTI stays 0.
//  2 BTN[1] toggling every 3 cycles for 40 cycles, then held steady
//    -> no strobe during bouncing; one strobe with IN=1, 18 edges after steady start.
//  3 BTN=4'b0011 held 30 cycles -> MULTI pulses once, IN_VALID stays 0, IN unchanged.
//  4 ENABLE=0, press BTN[3]; release; ENABLE=1, press BTN[3] again
//    -> first press gives no strobe; second gives IN=3, IN_VALID.
//  5 Press BTN[0] held 10 cycles, then pulse RST, keep holding; release 20 cycles; press BTN[2]
//    -> no strobe for BTN[0]; one strobe IN=2.
//  6 Press BTN[1], release for only 8 cycles, press BTN[1] again and hold
//    -> single strobe total; a new strobe only after a 16-cycle release, then a press.

Source files
------------

// File: rtl/button_encoder.sv
// button_encoder: synchronises, debounces and encodes four colour buttons.
// Ports: CLK, RST (sync, active-high), BTN[3:0] raw buttons, ENABLE,
//   IN[1:0] colour code, IN_VALID strobe, MULTI strobe, KEY_DOWN level.
module button_encoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       ENABLE,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       MULTI,
  output logic       KEY_DOWN
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    RELEASE_S,
    ARMED_S,
    PRESS_S
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]       sync;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       pat;
  logic [3:0]       pat_n;
  logic [1:0]       in_n;
  logic             valid_n;
  logic             multi_n;

  // Stage 0 takes the raw pins; the last stage is the
  // only one the rest of the block looks at.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], BTN};
    end
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign KEY_DOWN = |sync;

  // Saturating increment keeps the counter from wrapping.
  assign cnt_inc = (count == CNT_MAX) ?
                   count : count + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RELEASE_S;
      count    <= '0;
      pat      <= '0;
      IN       <= '0;
      IN_VALID <= 1'b0;
      MULTI    <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      pat      <= pat_n;
      IN       <= in_n;
      IN_VALID <= valid_n;
      MULTI    <= multi_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    pat_n   = pat;
    in_n    = IN;
    valid_n = 1'b0;
    multi_n = 1'b0;
    unique case (state)
      RELEASE_S: begin
        // Any key resets the release run; a full run arms.
        if (|sync) begin
          count_n = '0;
        end else if (count == CNT_LAST) begin
          state_n = ARMED_S;
          count_n = '0;
        end else begin
          count_n = cnt_inc;
        end
      end
      ARMED_S: begin
        if (|sync) begin
          pat_n   = sync;
          count_n = '0;
          state_n = PRESS_S;
        end
      end
      PRESS_S: begin
        // A change of pattern drops back to ARMED_S so the
        // next stable pattern starts a fresh debounce.
        if (sync != pat) begin
          state_n = ARMED_S;
        end else if (count == CNT_LAST) begin
          state_n = RELEASE_S;
          count_n = '0;
          if ($onehot(pat)) begin
            if (ENABLE) begin
              valid_n = 1'b1;
              unique case (1'b1)
                pat[0]:  in_n = 2'd0;
                pat[1]:  in_n = 2'd1;
                pat[2]:  in_n = 2'd2;
                pat[3]:  in_n = 2'd3;
                default: in_n = IN;
              endcase
            end
          end else begin
            multi_n = 1'b1;
          end
        end else begin
          count_n = cnt_inc;
        end
      end
      default: begin
        state_n = RELEASE_S;
        count_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_encoder.sv
// Bench for button_encoder: directed scenarios plus random
// button activity, checked each cycle against a run-length model.
module tb_button_encoder;

  localparam int SS = 2;
  localparam int DB = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] BTN;
  logic       ENABLE;
  logic [1:0] IN;
  logic       IN_VALID;
  logic       MULTI;
  logic       KEY_DOWN;

  int total = 0;
  int bad   = 0;
  int edges = 0;

  // reference model state
  logic [3:0] mp [SS];
  bit         armed;
  bit         holding;
  int         zrun;
  int         crun;
  logic [3:0] cand;
  logic [1:0] m_in;
  logic       m_valid;
  logic       m_multi;

  // per-scenario observations
  int         nv;
  int         nm;
  int         v_edge;
  logic [1:0] v_in;

  button_encoder #(
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BTN(BTN),
    .ENABLE(ENABLE),
    .IN(IN),
    .IN_VALID(IN_VALID),
    .MULTI(MULTI),
    .KEY_DOWN(KEY_DOWN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [1:0] idx(input logic [3:0] p);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (p[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] s;
    m_valid = 1'b0;
    m_multi = 1'b0;
    if (RST) begin
      for (int i = 0; i < SS; i++) mp[i] = 4'd0;
      armed   = 0;
      holding = 0;
      zrun    = 0;
      crun    = 0;
      cand    = 4'd0;
      m_in    = 2'd0;
      return;
    end
    s = mp[SS-1];
    if (!armed) begin
      if (s != 4'd0) zrun = 0;
      else begin
        zrun++;
        if (zrun == DB) begin
          armed = 1;
          zrun  = 0;
        end
      end
    end else if (!holding) begin
      if (s != 4'd0) begin
        holding = 1;
        cand    = s;
        crun    = 1;
      end
    end else if (s != cand) begin
      holding = 0;
    end else begin
      crun++;
      if (crun == DB + 1) begin
        armed   = 0;
        holding = 0;
        zrun    = 0;
        if ($countones(cand) == 1) begin
          if (ENABLE) begin
            m_in    = idx(cand);
            m_valid = 1'b1;
          end
        end else begin
          m_multi = 1'b1;
        end
      end
    end
    for (int i = SS - 1; i > 0; i--) mp[i] = mp[i-1];
    mp[0] = BTN;
  endtask

  task automatic check();
    total++;
    assert (IN_VALID === m_valid) else begin
      bad++;
      $error("FAIL in_valid: got %b exp %b edge %0d",
             IN_VALID, m_valid, edges);
    end
    total++;
    assert (MULTI === m_multi) else begin
      bad++;
      $error("FAIL multi: got %b exp %b edge %0d",
             MULTI, m_multi, edges);
    end
    total++;
    assert (IN === m_in) else begin
      bad++;
      $error("FAIL in: got %0d exp %0d edge %0d",
             IN, m_in, edges);
    end
    total++;
    assert (KEY_DOWN === (|mp[SS-1])) else begin
      bad++;
      $error("FAIL key_down: got %b exp %b edge %0d",
             KEY_DOWN, |mp[SS-1], edges);
    end
    total++;
    assert (!(IN_VALID === 1'b1 && MULTI === 1'b1)) else begin
      bad++;
      $error("FAIL excl: got valid=%b multi=%b exp not both",
             IN_VALID, MULTI);
    end
    if (IN_VALID === 1'b1) begin
      if (nv == 0) v_edge = edges;
      nv++;
      v_in = IN;
    end
    if (MULTI === 1'b1) nm++;
  endtask

  task automatic tick();
    @(posedge CLK);
    edges++;
    model_step();
    @(negedge CLK);
    check();
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    BTN = b;
    repeat (n) tick();
  endtask

  task automatic clr();
    nv     = 0;
    nm     = 0;
    v_edge = -1;
    v_in   = 2'd0;
  endtask

  task automatic expect_int(input string tag,
                            input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  initial begin
    int e0;
    int len;
    int r;
    logic [3:0] pat;
    RST    = 1'b1;
    BTN    = 4'd0;
    ENABLE = 1'b1;
    clr();
    for (int i = 0; i < SS; i++) mp[i] = 4'd0;
    tick();
    tick();
    RST = 1'b0;

    // 1: idle, then BTN[2] held
    hold(4'd0, 20);
    clr();
    e0 = edges + 1;
    hold(4'b0100, 30);
    expect_int("s1_count", nv, 1);
    expect_int("s1_in", int'(v_in), 2);
    expect_int("s1_latency", v_edge - e0, 18);
    expect_int("s1_multi", nm, 0);
    hold(4'd0, 20);

    // 2: bouncing BTN[1], then steady
    clr();
    for (int k = 0; k < 40; k++) begin
      BTN = (((k / 3) % 2) == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    expect_int("s2_bounce", nv, 0);
    e0 = edges + 1;
    hold(4'b0010, 30);
    expect_int("s2_count", nv, 1);
    expect_int("s2_in", int'(v_in), 1);
    expect_int("s2_latency", v_edge - e0, 18);
    hold(4'd0, 20);

    // 3: two buttons at once
    clr();
    hold(4'b0011, 30);
    expect_int("s3_multi", nm, 1);
    expect_int("s3_valid", nv, 0);
    expect_int("s3_in_hold", int'(IN), 1);
    hold(4'd0, 20);

    // 4: disabled press, then enabled press
    clr();
    ENABLE = 1'b0;
    hold(4'b1000, 30);
    expect_int("s4_disabled", nv, 0);
    hold(4'd0, 20);
    ENABLE = 1'b1;
    hold(4'b1000, 30);
    expect_int("s4_count", nv, 1);
    expect_int("s4_in", int'(v_in), 3);
    hold(4'd0, 20);

    // 5: reset in the middle of a press
    clr();
    hold(4'b0001, 10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    expect_int("s5_rst_in", int'(IN), 0);
    expect_int("s5_rst_key", int'(KEY_DOWN), 0);
    hold(4'b0001, 20);
    expect_int("s5_held", nv, 0);
    hold(4'd0, 20);
    hold(4'b0100, 30);
    expect_int("s5_count", nv, 1);
    expect_int("s5_in", int'(v_in), 2);
    hold(4'd0, 20);

    // 6: short release does not re-arm
    clr();
    hold(4'b0010, 30);
    hold(4'd0, 8);
    hold(4'b0010, 30);
    expect_int("s6_short", nv, 1);
    hold(4'd0, 20);
    hold(4'b0010, 30);
    expect_int("s6_rearm", nv, 2);

    // random activity against the model
    for (int seg = 0; seg < 60; seg++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) pat = 4'd0;
      else if (r < 8) pat = 4'(1 << $urandom_range(0, 3));
      else pat = 4'($urandom_range(1, 15));
      len = int'($urandom_range(1, 26));
      ENABLE = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
      end
      hold(pat, len);
    end
    hold(4'd0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
